// File: rtl/neuron_pkg.sv
// Shared definitions for the accumulate-and-fire neuron.
// Holds the state encoding (also exported on the debug state port),
// the default potential width that matches the upstream ripple-carry
// adder, and the saturated potential value for that default width.
package neuron_pkg;

   localparam int NEURON_WIDTH = 10;

   localparam logic [NEURON_WIDTH-1:0] VMAX = {NEURON_WIDTH{1'b1}};

   typedef enum logic [1:0] {
      INTEGRATE = 2'd0,
      FIRE      = 2'd1,
      REFRAC    = 2'd2
   } state_t;

endpackage

// File: rtl/neuron_leak_timer.sv
// Idle-cycle timer that paces the membrane leak.
// Counts enabled cycles and raises tick on the cycle in which the count
// sits at PERIOD-1; the count then wraps to zero. A PERIOD of 0 never
// ticks. Synchronous active-high reset.
// Ports:
//   clk    - rising-edge clock
//   rst    - synchronous reset, clears the count
//   clear  - restart the idle count (an input was accepted)
//   enable - this is an idle integrate cycle, advance the count
//   tick   - combinational: a leak step happens on this edge
module neuron_leak_timer #(
   parameter int PERIOD = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

   logic [CW-1:0] count;
   logic          at_end;

   assign at_end = (count == CW'(PERIOD - 1));
   assign tick   = (PERIOD != 0) && enable && at_end;

   // The count wraps when it reaches the last idle cycle of a period, so a
   // leak step lands on every PERIOD-th consecutive idle cycle. A clear
   // restarts the period so the leak never fires right after an input.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= at_end ? '0 : count + CW'(1);
      end
   end

endmodule

// File: rtl/neuron_accum_fire.sv
// Membrane-potential register and fire logic downstream of the adder.
// The adder sum (saturated on carry-out) becomes the new potential; the
// potential is fed back as the adder's A operand. Reaching threshold
// produces a one-cycle spike, reloads VRESET and blocks input for a
// refractory period. While idle in INTEGRATE a periodic leak decrements
// the potential, flooring at zero.
// Ports:
//   CLK      - rising-edge clock
//   RST      - synchronous active-high reset
//   IN_VALID - SUM/COUT valid this cycle
//   IN_READY - input accepted this cycle (INTEGRATE only)
//   SUM      - adder sum
//   COUT     - adder carry-out, 1 means overflow
//   THRESH   - unsigned firing threshold, used on accept
//   V_OUT    - registered membrane potential
//   SPIKE    - registered one-cycle fire pulse
//   STATE_O  - current state encoding for debug
module neuron_accum_fire
   import neuron_pkg::*;
#(
   parameter int WIDTH       = NEURON_WIDTH,
   parameter int VRESET      = 0,
   parameter int REFRAC_CYC  = 3,
   parameter int LEAK_PERIOD = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [WIDTH-1:0] SUM,
   input  logic             COUT,
   input  logic [WIDTH-1:0] THRESH,
   output logic [WIDTH-1:0] V_OUT,
   output logic             SPIKE,
   output logic [1:0]       STATE_O
);

   localparam int RW = (REFRAC_CYC > 1) ? $clog2(REFRAC_CYC) : 1;

   state_t           state;
   state_t           next_state;
   logic             accept;
   logic [WIDTH-1:0] vnext;
   logic             crossed;
   logic             leak_tick;
   logic [RW-1:0]    refrac_cnt;

   assign accept  = IN_VALID && (state == INTEGRATE);
   assign vnext   = COUT ? {WIDTH{1'b1}} : SUM;
   assign crossed = (vnext >= THRESH);
   assign STATE_O = state;

   // The leak timer only advances on idle integrate cycles; during fire
   // and refractory it simply holds (it was already cleared by the
   // accepted input that caused the fire).
   neuron_leak_timer #(
      .PERIOD (LEAK_PERIOD)
   ) u_leak (
      .clk    (CLK),
      .rst    (RST),
      .clear  (accept),
      .enable ((state == INTEGRATE) && !accept),
      .tick   (leak_tick)
   );

   // State register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= INTEGRATE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode and the ready output. Only an accepted input can
   // cause a fire; the leak can only lower the potential so it never
   // needs a threshold compare.
   always_comb begin
      next_state = state;
      IN_READY   = 1'b0;
      case (state)
         INTEGRATE: begin
            IN_READY = 1'b1;
            if (accept && crossed) begin
               next_state = FIRE;
            end
         end
         FIRE: begin
            next_state = (REFRAC_CYC > 0) ? REFRAC : INTEGRATE;
         end
         REFRAC: begin
            if (refrac_cnt == '0) begin
               next_state = INTEGRATE;
            end
         end
         default: begin
            next_state = INTEGRATE;
         end
      endcase
   end

   // Potential, refractory counter and spike register. The spike is the
   // registered "entering FIRE" flag, so it is high exactly while the
   // state register holds FIRE. An accept beats a coincident leak tick
   // because the leak timer's enable is suppressed by the accept.
   always_ff @(posedge CLK) begin
      if (RST) begin
         V_OUT      <= WIDTH'(VRESET);
         refrac_cnt <= '0;
         SPIKE      <= 1'b0;
      end else begin
         SPIKE <= (next_state == FIRE);
         case (state)
            INTEGRATE: begin
               if (accept) begin
                  V_OUT <= vnext;
               end else if (leak_tick && (V_OUT != '0)) begin
                  V_OUT <= V_OUT - WIDTH'(1);
               end
            end
            FIRE: begin
               V_OUT <= WIDTH'(VRESET);
               if (REFRAC_CYC > 0) begin
                  refrac_cnt <= RW'(REFRAC_CYC - 1);
               end
            end
            REFRAC: begin
               if (refrac_cnt != '0) begin
                  refrac_cnt <= refrac_cnt - RW'(1);
               end
            end
            default: begin
               refrac_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_neuron_accum_fire.sv
// Self-checking bench for neuron_accum_fire with default parameters.
// A table of directed vectors walks through reset, integrate, fire,
// dropped input during refractory, overflow and reset-in-refractory;
// hand-written sequences cover leak pacing and accept-on-leak-tick; a
// randomized phase compares against a cycle-level behavioural model
// expressed as "busy cycles remaining" and "idle cycles since input".
module tb_neuron_accum_fire;

   localparam int LEAK   = 4;
   localparam int REFRAC = 3;

   logic       CLK;
   logic       RST;
   logic       IN_VALID;
   logic       IN_READY;
   logic [9:0] SUM;
   logic       COUT;
   logic [9:0] THRESH;
   logic [9:0] V_OUT;
   logic       SPIKE;
   logic [1:0] STATE_O;

   int total;
   int bad;

   typedef struct {
      logic       rst;
      logic       valid;
      logic [9:0] sum;
      logic       cout;
      logic [9:0] thresh;
      logic [9:0] v;
      logic       spike;
      logic       ready;
      logic [1:0] st;
   } vec_t;

   vec_t vecs[14];

   neuron_accum_fire dut (
      .CLK      (CLK),
      .RST      (RST),
      .IN_VALID (IN_VALID),
      .IN_READY (IN_READY),
      .SUM      (SUM),
      .COUT     (COUT),
      .THRESH   (THRESH),
      .V_OUT    (V_OUT),
      .SPIKE    (SPIKE),
      .STATE_O  (STATE_O)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   function automatic vec_t mk(input int r, input int vl, input int s, input int c,
                               input int th, input int ev, input int es, input int er,
                               input int est);
      vec_t x;
      x.rst    = 1'(r);
      x.valid  = 1'(vl);
      x.sum    = 10'(s);
      x.cout   = 1'(c);
      x.thresh = 10'(th);
      x.v      = 10'(ev);
      x.spike  = 1'(es);
      x.ready  = 1'(er);
      x.st     = 2'(est);
      return x;
   endfunction

   // Drive one cycle of inputs, then sample 1 unit after the active edge.
   task automatic applyStimulus(input logic r, input logic vl, input logic [9:0] s,
                                input logic c, input logic [9:0] th);
      RST      = r;
      IN_VALID = vl;
      SUM      = s;
      COUT     = c;
      THRESH   = th;
      @(posedge CLK);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [9:0] ev, input logic es,
                              input logic er, input logic [1:0] est);
      total++;
      if (V_OUT !== ev) begin
         bad++;
         $display("[TB] FAIL %s V_OUT got=%0d want=%0d", name, V_OUT, ev);
      end
      total++;
      if (SPIKE !== es) begin
         bad++;
         $display("[TB] FAIL %s SPIKE got=%0b want=%0b", name, SPIKE, es);
      end
      total++;
      if (IN_READY !== er) begin
         bad++;
         $display("[TB] FAIL %s IN_READY got=%0b want=%0b", name, IN_READY, er);
      end
      total++;
      if (STATE_O !== est) begin
         bad++;
         $display("[TB] FAIL %s STATE_O got=%0d want=%0d", name, STATE_O, est);
      end
   endtask

   initial begin
      int   m_v;
      int   m_busy;
      int   m_idle;
      bit   m_spike;
      bit   prev_spike;
      logic r, vl, c;
      logic [9:0] s, th;
      int   ev;

      total    = 0;
      bad      = 0;
      RST      = 1'b1;
      IN_VALID = 1'b0;
      SUM      = '0;
      COUT     = 1'b0;
      THRESH   = 10'd500;

      vecs[0]  = mk(1, 0,   0, 0,  500,    0, 0, 1, 0);
      vecs[1]  = mk(1, 0,   0, 0,  500,    0, 0, 1, 0);
      vecs[2]  = mk(0, 1, 200, 0,  500,  200, 0, 1, 0);
      vecs[3]  = mk(0, 1, 600, 0,  500,  600, 1, 0, 1);
      vecs[4]  = mk(0, 1, 900, 0,  500,    0, 0, 0, 2);
      vecs[5]  = mk(0, 1, 900, 0,  500,    0, 0, 0, 2);
      vecs[6]  = mk(0, 1, 900, 0,  500,    0, 0, 0, 2);
      vecs[7]  = mk(0, 1, 900, 0,  500,    0, 0, 1, 0);
      vecs[8]  = mk(0, 1,   5, 1, 1023, 1023, 1, 0, 1);
      vecs[9]  = mk(0, 0,   0, 0,  500,    0, 0, 0, 2);
      vecs[10] = mk(0, 0,   0, 0,  500,    0, 0, 0, 2);
      vecs[11] = mk(1, 0,   0, 0,  500,    0, 0, 1, 0);
      vecs[12] = mk(1, 0,   0, 0,  500,    0, 0, 1, 0);
      vecs[13] = mk(0, 1,   3, 0,  500,    3, 0, 1, 0);

      for (int i = 0; i < 14; i++) begin
         applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].sum, vecs[i].cout, vecs[i].thresh);
         checkOutput($sformatf("vec%0d", i), vecs[i].v, vecs[i].spike, vecs[i].ready, vecs[i].st);
      end

      for (int k = 1; k <= 16; k++) begin
         ev = 3 - k / LEAK;
         if (ev < 0) ev = 0;
         applyStimulus(1'b0, 1'b0, 10'd0, 1'b0, 10'd500);
         checkOutput($sformatf("leak%0d", k), 10'(ev), 1'b0, 1'b1, 2'd0);
      end

      for (int k = 0; k < LEAK - 1; k++) begin
         applyStimulus(1'b0, 1'b0, 10'd0, 1'b0, 10'd500);
      end
      applyStimulus(1'b0, 1'b1, 10'd100, 1'b0, 10'd500);
      checkOutput("sim_accept", 10'd100, 1'b0, 1'b1, 2'd0);
      for (int k = 1; k <= LEAK; k++) begin
         applyStimulus(1'b0, 1'b0, 10'd0, 1'b0, 10'd500);
         checkOutput($sformatf("sim_idle%0d", k), (k == LEAK) ? 10'd99 : 10'd100,
                     1'b0, 1'b1, 2'd0);
      end

      m_v        = 0;
      m_busy     = 0;
      m_idle     = 0;
      m_spike    = 0;
      prev_spike = 1'b0;
      for (int i = 0; i < 400; i++) begin
         r  = (i == 0) || ($urandom_range(0, 39) == 0);
         vl = ($urandom_range(0, 3) == 0);
         s  = 10'($urandom_range(0, 1023));
         c  = ($urandom_range(0, 7) == 0);
         th = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023))
                                          : 10'($urandom_range(600, 1023));

         if (r) begin
            m_v = 0; m_busy = 0; m_idle = 0; m_spike = 0;
         end else if (m_busy > 0) begin
            if (m_spike) m_v = 0;
            m_spike = 0;
            m_busy--;
         end else if (vl) begin
            m_v    = c ? 1023 : int'(s);
            m_idle = 0;
            if (m_v >= int'(th)) begin
               m_spike = 1;
               m_busy  = 1 + REFRAC;
            end
         end else begin
            m_idle++;
            if (m_idle == LEAK) begin
               m_idle = 0;
               if (m_v > 0) m_v--;
            end
         end

         applyStimulus(r, vl, s, c, th);
         checkOutput($sformatf("rand%0d", i), 10'(m_v), m_spike, (m_busy == 0),
                     m_spike ? 2'd1 : ((m_busy > 0) ? 2'd2 : 2'd0));
         total++;
         if (prev_spike && SPIKE) begin
            bad++;
            $display("[TB] FAIL rand%0d spike_pair got=11 want=not both high", i);
         end
         prev_spike = SPIKE;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/neuron_accum_fire.md
Name: neuron_accum_fire

Overview:
Membrane-potential register and fire logic that sits directly downstream of the 10-bit ripple-carry full adder. It captures the adder's sum and carry-out as the new potential, saturating on overflow, and feeds the potential back to the adder's A operand. When the potential reaches threshold it emits a one-cycle spike, reloads a reset potential and holds off input for a refractory period. While idle it applies a periodic leak.

Parameters:
WIDTH, 10, potential/sum width; matches the adder
VRESET, 0, potential loaded after a spike
REFRAC_CYC, 3, refractory length in cycles; 0 means no refractory
LEAK_PERIOD, 4, idle cycles per leak decrement of 1; 0 disables leak

Ports:
CLK  in  1  single clock, rising edge
RST  in  1  synchronous, active-high reset
IN_VALID  in  1  SUM/COUT from the adder are valid this cycle
IN_READY  out  1  block accepts input; high only in INTEGRATE
SUM  in  WIDTH  adder Sout
COUT  in  1  adder Cout; 1 means overflow
THRESH  in  WIDTH  firing threshold, unsigned; sampled when input is accepted
V_OUT  out  WIDTH  registered membrane potential; drives adder A input
SPIKE  out  1  registered one-cycle fire pulse
STATE_O  out  2  current state encoding, for debug

Behaviour:
- One clock domain (CLK). Reset is synchronous and active-high (RST).
- Reset values: V_OUT=VRESET, SPIKE=0, state=INTEGRATE, refractory counter=0, leak counter=0. IN_READY=1 from the first cycle after reset.
- RST asserted mid-operation overrides everything on that edge, in any state.
- Accept = IN_VALID && IN_READY. IN_VALID while IN_READY=0 is dropped silently; there is no backpressure buffering.
- Saturation: vnext = COUT ? 2^WIDTH-1 : SUM.
- States: INTEGRATE=0, FIRE=1, REFRAC=2.
- INTEGRATE, on accept:
  - V_OUT <= vnext; leak counter <= 0.
  - If vnext >= THRESH: state <= FIRE.
  - Latency: input edge n updates V_OUT at n+1; SPIKE is high during cycle n+1 to n+2.
- INTEGRATE, no accept:
  - Leak counter increments.
  - When it reaches LEAK_PERIOD-1: V_OUT <= V_OUT-1 if V_OUT>0 (floor at 0), and the counter wraps to 0.
  - The leak never triggers a fire.
- Accept and leak tick in the same cycle: the accept wins and the leak is discarded.
- FIRE lasts exactly 1 cycle, with SPIKE=1 and IN_READY=0. Next edge:
  - V_OUT <= VRESET.
  - If REFRAC_CYC>0: state <= REFRAC and counter <= REFRAC_CYC-1.
  - Otherwise: state <= INTEGRATE.
- REFRAC: IN_READY=0, no leak. The counter decrements each cycle; when it is 0, state <= INTEGRATE.
  - Input is therefore blocked for 1 (FIRE) + REFRAC_CYC cycles after the spike edge.
- THRESH=0: every accepted input fires.
- THRESH=2^WIDTH-1: fires only when the potential saturates or SUM equals all-ones.
- SPIKE is never high on two consecutive cycles.
- All outputs are registered except IN_READY, which decodes from the state register only.

Decomposition:
- Package neuron_pkg holds:
  - state_t enum {INTEGRATE, FIRE, REFRAC}
  - WIDTH default
  - localparam VMAX = 2^WIDTH-1
- One sub-module, neuron_leak_timer: leak counter with a clear input and a tick output.
- The FSM, saturation and compare stay in the top module.

Test Plan:
- Reset: assert RST for 2 cycles mid-REFRAC -> V_OUT=0, SPIKE=0, STATE_O=0, IN_READY=1 on the next cycle.
- Sub-threshold: THRESH=500, accept SUM=200, COUT=0 -> V_OUT=200 next cycle, SPIKE stays 0.
- Fire: THRESH=500, accept SUM=600 -> V_OUT=600 and SPIKE=1 for one cycle. Then V_OUT=0, IN_READY=0 for 1+3 cycles. An IN_VALID with SUM=900 driven during this window is ignored (V_OUT stays 0, no spike).
- Overflow: accept SUM=5, COUT=1, THRESH=1023 -> V_OUT=1023 and SPIKE=1.
- Leak: V_OUT=3, no input for 16 cycles -> V_OUT goes 2, 1, 0 on every 4th cycle, then holds at 0 with no underflow.
- Simultaneous: IN_VALID on the exact leak-tick cycle with SUM=100 -> V_OUT=100 (no decrement), and the next decrement occurs 4 idle cycles later.
